// File: rtl/lb_sdram_fetch.sv
// Line-buffer fetch engine for the VGA path.
// Each scanline it fetches the next visible line of 16-bit pixels from SDRAM, through the
// arbiter's Line_buffer port, into one bank of a ping-pong buffer. Line L goes to bank L[0].
// The line being displayed is read from bank DrawY[0] at DrawX.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   new_frame        vblank pulse, starts the fetch of line 0
//   DrawX, DrawY     current raster position
//   lb_sdram_rd      read request to the arbiter
//   lb_sdram_addr    word address of the current request
//   lb_Busy          fetch pending or running; the arbiter holds the grant while high
//   lb_sdram_Wait    0 = SDRAM granted to this block
//   lb_sdram_ac      1-cycle acknowledge, lb_sdram_data valid in the same cycle
//   lb_sdram_data    read data
//   pixel_out        pixel at (DrawX, DrawY), 1 cycle latency, 0 when not visible
//   pixel_valid      pixel_out is a visible fetched pixel
module lb_sdram_fetch #(
    parameter int unsigned LINE_PIXELS = 640,
    parameter int unsigned VIS_LINES   = 480,
    parameter int unsigned LINE_STRIDE = 640,
    parameter logic [24:0] BASE_ADDR   = 25'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_frame,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        lb_sdram_rd,
    output logic [24:0] lb_sdram_addr,
    output logic        lb_Busy,
    input  logic        lb_sdram_Wait,
    input  logic        lb_sdram_ac,
    input  logic [15:0] lb_sdram_data,
    output logic [15:0] pixel_out,
    output logic        pixel_valid
);

    typedef enum logic [1:0] {StIdle, StGrant, StRead} state_e;

    state_e      state_q, state_d;
    logic [9:0]  tgt_q, tgt_d;
    logic [9:0]  idx_q, idx_d;
    logic [24:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [15:0] pix_q;

    logic        trig;
    logic [9:0]  trig_line;
    logic        last_word;
    logic        wr_en;
    logic [10:0] rd_idx;

    // Both banks live in one array; bit 10 of the index selects the bank.
    logic [15:0] mem [2048];

    // Fetch trigger: new_frame takes priority over the end-of-line trigger.
    always_comb begin
        trig      = 1'b0;
        trig_line = '0;
        if (new_frame) begin
            trig = 1'b1;
        end else if (DrawX == 10'd799 && 32'(DrawY) < VIS_LINES - 1) begin
            trig      = 1'b1;
            trig_line = DrawY + 10'd1;
        end
    end

    assign last_word = (32'(idx_q) == LINE_PIXELS - 1);
    // An ac is only honoured against an outstanding request; reset blocks the write.
    assign wr_en     = (state_q == StRead) && lb_sdram_ac && !reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        valid_d = (32'(DrawX) < LINE_PIXELS) && (32'(DrawY) < VIS_LINES);

        unique case (state_q)
            StIdle:  if (trig) state_d = StGrant;
            StGrant: if (!lb_sdram_Wait) state_d = StRead;
            StRead: begin
                // Losing the grant abandons the rest of the line.
                if (lb_sdram_Wait || (lb_sdram_ac && last_word)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (wr_en) begin
            idx_d  = idx_q + 10'd1;
            addr_d = addr_q + 25'd1;
        end

        // A trigger while busy is an overrun: restart on the new line.
        if (trig) begin
            state_d = StGrant;
            tgt_d   = trig_line;
            idx_d   = '0;
            addr_d  = BASE_ADDR + 25'(trig_line) * 25'(LINE_STRIDE);
        end
    end

    // Outputs
    always_comb begin
        lb_sdram_rd   = (state_q == StRead);
        lb_sdram_addr = addr_q;
        lb_Busy       = (state_q != StIdle) || trig;
        pixel_valid   = valid_q;
        pixel_out     = valid_q ? pix_q : 16'h0;
    end

    assign rd_idx = {DrawY[0], DrawX};

    // Line buffer RAM: one write port (fetch), one registered read port (display).
    always_ff @(posedge clk) begin
        if (wr_en) mem[{tgt_q[0], idx_q}] <= lb_sdram_data;
        pix_q <= mem[rd_idx];
    end

endmodule

// File: tb/tb_lb_sdram_fetch.sv
// Bench for lb_sdram_fetch: a job-level model (current fetch job, shadow line buffers) is
// compared against the DUT every cycle, plus literal checks on the directed scenarios.
module tb_lb_sdram_fetch;

    localparam int LP = 640;
    localparam int VL = 480;
    localparam int LS = 640;
    localparam logic [24:0] BA = 25'h0;

    logic        clk = 1'b0;
    logic        reset, new_frame, lb_sdram_Wait, lb_sdram_ac;
    logic [9:0]  DrawX, DrawY;
    logic [15:0] lb_sdram_data;
    logic        lb_sdram_rd, lb_Busy, pixel_valid;
    logic [24:0] lb_sdram_addr;
    logic [15:0] pixel_out;

    always #5 clk = ~clk;

    lb_sdram_fetch #(
        .LINE_PIXELS(LP),
        .VIS_LINES  (VL),
        .LINE_STRIDE(LS),
        .BASE_ADDR  (BA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .new_frame    (new_frame),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .lb_sdram_rd  (lb_sdram_rd),
        .lb_sdram_addr(lb_sdram_addr),
        .lb_Busy      (lb_Busy),
        .lb_sdram_Wait(lb_sdram_Wait),
        .lb_sdram_ac  (lb_sdram_ac),
        .lb_sdram_data(lb_sdram_data),
        .pixel_out    (pixel_out),
        .pixel_valid  (pixel_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a fetch job is active (waiting for grant or requesting), with line and next word.
    bit          m_active, m_req;
    int          m_line, m_idx;
    int          acks;
    logic [15:0] sh [2048];
    bit          sh_known [2048];
    bit          e_valid, e_known;
    logic [15:0] e_pix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare at the falling edge, then advance the model with the inputs of this cycle.
    task automatic step();
        bit tr;
        int tl, ridx, widx;
        bit nv, wr;
        @(negedge clk);
        tr = 1'b0;
        tl = 0;
        if (new_frame) tr = 1'b1;
        else if (DrawX == 10'd799 && int'(DrawY) < VL - 1) begin
            tr = 1'b1;
            tl = int'(DrawY) + 1;
        end
        chk("rd", 32'(lb_sdram_rd), 32'(m_req));
        if (m_req) chk("addr", 32'(lb_sdram_addr), 32'(25'(int'(BA) + m_line * LS + m_idx)));
        chk("busy", 32'(lb_Busy), 32'(m_active || tr));
        chk("pixel_valid", 32'(pixel_valid), 32'(e_valid));
        if (!e_valid) chk("pixel_zero", 32'(pixel_out), 32'd0);
        else if (e_known) chk("pixel", 32'(pixel_out), 32'(e_pix));

        nv      = (int'(DrawX) < LP) && (int'(DrawY) < VL);
        ridx    = int'(DrawY[0]) * 1024 + int'(DrawX);
        e_pix   = sh[ridx];
        e_known = sh_known[ridx];
        if (reset) begin
            m_active = 1'b0;
            m_req    = 1'b0;
            e_valid  = 1'b0;
        end else begin
            e_valid = nv;
            wr = m_req && lb_sdram_ac;
            if (wr) begin
                widx = (m_line % 2) * 1024 + m_idx;
                sh[widx] = lb_sdram_data;
                sh_known[widx] = 1'b1;
                acks++;
                if (widx / 1024 == ridx / 1024) e_known = 1'b0;
            end
            if (tr) begin
                m_active = 1'b1;
                m_req    = 1'b0;
                m_line   = tl;
                m_idx    = 0;
            end else if (m_req) begin
                if (wr) m_idx++;
                if (lb_sdram_Wait || m_idx == LP) begin
                    m_active = 1'b0;
                    m_req    = 1'b0;
                end
            end else if (m_active && !lb_sdram_Wait) begin
                m_req = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Serve the active job to completion (or until the budget runs out).
    task automatic fetch(input bit every3, input bit data_idx, input int budget);
        int n = 0;
        int c = 0;
        while (m_active && n < budget) begin
            if (every3) lb_sdram_ac = m_req && (c % 3 == 2);
            else lb_sdram_ac = ($urandom % 4 != 0);
            lb_sdram_data = data_idx ? 16'(m_idx) : 16'($urandom);
            if (m_req) c++;
            step();
            n++;
        end
        lb_sdram_ac = 1'b0;
        chk("fetch_done_busy", 32'(lb_Busy), 32'd0);
    endtask

    task automatic pulse_nf();
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
    endtask

    initial begin
        int start, n;
        reset = 1'b1; new_frame = 1'b0; DrawX = '0; DrawY = 10'd500;
        lb_sdram_Wait = 1'b0; lb_sdram_ac = 1'b0; lb_sdram_data = '0;
        for (int i = 0; i < 2048; i++) sh_known[i] = 1'b0;
        m_active = 1'b0; m_req = 1'b0; m_line = 0; m_idx = 0; acks = 0;
        e_valid = 1'b0; e_known = 1'b0; e_pix = '0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        chk("reset_rd", 32'(lb_sdram_rd), 32'd0);
        chk("reset_busy", 32'(lb_Busy), 32'd0);
        chk("reset_addr", 32'(lb_sdram_addr), 32'd0);
        chk("reset_valid", 32'(pixel_valid), 32'd0);
        chk("reset_pixel", 32'(pixel_out), 32'd0);

        // 1: line 0, ac every 3rd request cycle, data = word index
        pulse_nf();
        step();
        chk("t1_first_rd", 32'(lb_sdram_rd), 32'd1);
        chk("t1_first_addr", 32'(lb_sdram_addr), 32'd0);
        start = acks;
        fetch(1'b1, 1'b1, 3000);
        chk("t1_acks", 32'(acks - start), 32'd640);

        // 2: end-of-line trigger on row 0 fetches line 1
        DrawY = 10'd0; DrawX = 10'd799;
        #1;
        chk("t2_busy_same_cycle", 32'(lb_Busy), 32'd1);
        step();
        DrawX = 10'd0;
        step();
        chk("t2_first_rd", 32'(lb_sdram_rd), 32'd1);
        chk("t2_first_addr", 32'(lb_sdram_addr), 32'd640);
        fetch(1'b0, 1'b0, 5000);

        // 3: scan row 0, bank 0 holds word index
        for (int x = 0; x < 800; x++) begin
            DrawX = 10'(x);
            step();
            if (x < 640) chk("t3_pixel", 32'(pixel_out), 32'(x));
            else begin
                chk("t3_pixel_zero", 32'(pixel_out), 32'd0);
                chk("t3_invalid", 32'(pixel_valid), 32'd0);
            end
        end
        DrawX = 10'd0;
        fetch(1'b0, 1'b0, 5000);
        DrawY = 10'd1;
        for (int x = 0; x < 640; x++) begin
            DrawX = 10'(x);
            step();
        end

        // 4: grant withheld, then grant lost at word 100
        DrawY = 10'd500; DrawX = 10'd0;
        lb_sdram_Wait = 1'b1;
        pulse_nf();
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t4_grant_rd", 32'(lb_sdram_rd), 32'd0);
            chk("t4_grant_busy", 32'(lb_Busy), 32'd1);
        end
        lb_sdram_Wait = 1'b0;
        n = 0;
        while (!(m_req && m_idx == 100) && n < 400) begin
            lb_sdram_ac = m_req;
            lb_sdram_data = 16'(m_idx);
            step();
            n++;
        end
        lb_sdram_ac = 1'b0;
        lb_sdram_Wait = 1'b1;
        step();
        chk("t4_lost_rd", 32'(lb_sdram_rd), 32'd0);
        chk("t4_lost_busy", 32'(lb_Busy), 32'd0);
        lb_sdram_Wait = 1'b0;
        for (int i = 0; i < 50; i++) begin
            lb_sdram_ac = 1'($urandom);
            step();
            chk("t4_idle_rd", 32'(lb_sdram_rd), 32'd0);
        end
        lb_sdram_ac = 1'b0;

        // 5: last fetched line, and no trigger from the last visible row
        DrawY = 10'd478; DrawX = 10'd799;
        step();
        DrawX = 10'd0;
        step();
        chk("t5_first_addr", 32'(lb_sdram_addr), 32'd306560);
        fetch(1'b0, 1'b0, 5000);
        DrawY = 10'd479; DrawX = 10'd799;
        #1;
        chk("t5_no_trigger", 32'(lb_Busy), 32'd0);
        step();
        step();
        chk("t5_still_idle", 32'(lb_Busy), 32'd0);

        // 6: reset during a held ac
        DrawY = 10'd500; DrawX = 10'd0;
        pulse_nf();
        step();
        lb_sdram_ac = 1'b1;
        lb_sdram_data = 16'hBEEF;
        step();
        reset = 1'b1;
        lb_sdram_data = 16'hCAFE;
        step();
        reset = 1'b0;
        lb_sdram_ac = 1'b0;
        chk("t6_rd", 32'(lb_sdram_rd), 32'd0);
        chk("t6_busy", 32'(lb_Busy), 32'd0);
        DrawY = 10'd0;
        step();
        chk("t6_written", 32'(pixel_out), 32'hBEEF);
        DrawX = 10'd1;
        step();
        chk("t6_not_written", 32'(pixel_out), 32'd1);

        // Random raster with random grant, ac, frame pulses and resets
        DrawY = 10'd474; DrawX = 10'd0;
        for (int i = 0; i < 6000; i++) begin
            new_frame     = ($urandom % 900 == 0);
            reset         = ($urandom % 1500 == 0);
            lb_sdram_Wait = ($urandom % 40 == 0);
            lb_sdram_ac   = ($urandom % 4 != 0);
            lb_sdram_data = 16'($urandom);
            step();
            if (DrawX == 10'd799) begin
                DrawX = 10'd0;
                DrawY = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
            end else begin
                DrawX = DrawX + 10'd1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
